smart_home_annunciator: RTL and testbench

Output-side companion to the smart-home controller FSM. It consumes the controller's 3-bit `display` state code and turns it into timed physical actions:
- door-actuator pulses of bounded length;
- a buzzer tone, with cadence, that the user can silence;
- a seven-segment digit;
- a saturating event counter.

It sits between the controller's `display[2:0]` output and the board-level actuators/LEDs.

---
 rtl/smart_home_annunciator_pkg.sv | 53 +++++
 rtl/smart_home_annunciator_tone_gen.sv | 37 +++
 rtl/smart_home_annunciator.sv | 128 ++++++++++++
 tb/tb_smart_home_annunciator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/smart_home_annunciator_pkg.sv
// Shared types and constants for the smart-home annunciator: state encoding,
// controller-code decoding and seven-segment glyphs.
package smart_home_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DOOR_F = 3'd1,
    DOOR_R = 3'd2,
    ALARM  = 3'd3,
    WINDOW = 3'd4,
    HEAT   = 3'd5,
    COOL   = 3'd6
  } state_t;

  localparam logic [7:0] EVT_MAX = 8'hFF;

  // Seven-segment glyphs, active-high, bit order gfedcba.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;

  // Controller display code to annunciator state; both cooler codes fold to COOL.
  function automatic state_t code_to_state(input logic [2:0] code);
    case (code)
      3'b000:  return IDLE;
      3'b001:  return DOOR_F;
      3'b010:  return DOOR_R;
      3'b011:  return ALARM;
      3'b100:  return WINDOW;
      3'b101:  return HEAT;
      default: return COOL;
    endcase
  endfunction

  // Decimal digit of the state on the display.
  function automatic logic [6:0] state_to_seg(input state_t s);
    case (s)
      IDLE:    return SEG_0;
      DOOR_F:  return SEG_1;
      DOOR_R:  return SEG_2;
      ALARM:   return SEG_3;
      WINDOW:  return SEG_4;
      HEAT:    return SEG_5;
      COOL:    return SEG_6;
      default: return SEG_0;
    endcase
  endfunction

endpackage

// File: rtl/smart_home_annunciator_tone_gen.sv
// Buzzer square-wave generator: half-period of TONE_DIV cycles.
// en low holds the output low; clr restarts the phase with the output high.
module tone_gen #(
  parameter int TONE_DIV = 4
) (
  input  logic clk,
  input  logic Rst_n,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int CW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(TONE_DIV - 1);

  logic [CW-1:0] div_cnt;

  // Divider and toggle flop; output is registered so buzz is glitch-free.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      tone    <= 1'b0;
    end else if (clr) begin
      div_cnt <= '0;
      tone    <= 1'b1;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tone    <= ~tone;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/smart_home_annunciator.sv
// Annunciator: turns the controller's display code into door pulses, a
// mutable buzzer tone (cadenced for the window alert), a seven-segment digit
// and a saturating change counter. All outputs are registered.
module smart_home_annunciator
  import smart_home_pkg::*;
#(
  parameter int DOOR_HOLD = 8,
  parameter int TONE_DIV  = 4,
  parameter int CADENCE   = 16
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic [2:0] display_in,
  input  logic       ack,
  output logic       door_open_f,
  output logic       door_open_r,
  output logic       buzz,
  output logic [6:0] seg,
  output logic [7:0] evt_count,
  output logic       busy
);

  localparam int HW  = $clog2(DOOR_HOLD + 1);
  localparam int CDW = (CADENCE > 1) ? $clog2(CADENCE) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(DOOR_HOLD - 1);
  localparam logic [CDW-1:0] CAD_LAST  = CDW'(CADENCE - 1);

  // Handshake-free block: display_in and ack are level inputs sampled every edge.
  state_t         state;
  state_t         ns;
  logic           change;
  logic [HW-1:0]  hold, hold_nx;
  logic [CDW-1:0] cad, cad_nx;
  logic           cad_off, cad_off_nx;
  logic           mute, mute_nx;
  logic           door_f_nx, door_r_nx;
  logic           sound_nx, tone_clr, busy_nx;

  // Next-state and next-output decode; everything lands in flops below.
  always_comb begin
    ns         = code_to_state(display_in);
    change     = (ns != state);
    mute_nx    = mute;
    hold_nx    = hold;
    door_f_nx  = door_open_f;
    door_r_nx  = door_open_r;
    cad_nx     = cad;
    cad_off_nx = cad_off;
    tone_clr   = change;

    // A change always wins over ack; ack only matters while a tone state is held.
    if (change) begin
      mute_nx = 1'b0;
    end else if (ack && (state == ALARM || state == WINDOW)) begin
      mute_nx = 1'b1;
    end

    // Door pulse: armed on entry, counts DOOR_HOLD cycles, never re-arms in place.
    if (change) begin
      hold_nx   = '0;
      door_f_nx = (ns == DOOR_F);
      door_r_nx = (ns == DOOR_R);
    end else if (door_open_f || door_open_r) begin
      if (hold == HOLD_LAST) begin
        door_f_nx = 1'b0;
        door_r_nx = 1'b0;
      end else begin
        hold_nx = hold + 1'b1;
      end
    end

    // Window cadence: on-window first; each new on-window restarts tone phase.
    if (change) begin
      cad_nx     = '0;
      cad_off_nx = 1'b0;
    end else if (state == WINDOW) begin
      if (cad == CAD_LAST) begin
        cad_nx     = '0;
        cad_off_nx = ~cad_off;
        tone_clr   = cad_off;
      end else begin
        cad_nx = cad + 1'b1;
      end
    end

    sound_nx = !mute_nx && (ns == ALARM || (ns == WINDOW && !cad_off_nx));
    busy_nx  = door_f_nx || door_r_nx ||
               (!mute_nx && (ns == ALARM || ns == WINDOW));
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      cad         <= '0;
      cad_off     <= 1'b0;
      mute        <= 1'b0;
      door_open_f <= 1'b0;
      door_open_r <= 1'b0;
      busy        <= 1'b0;
      seg         <= SEG_0;
      evt_count   <= '0;
    end else begin
      state       <= ns;
      hold        <= hold_nx;
      cad         <= cad_nx;
      cad_off     <= cad_off_nx;
      mute        <= mute_nx;
      door_open_f <= door_f_nx;
      door_open_r <= door_r_nx;
      busy        <= busy_nx;
      seg         <= state_to_seg(ns);
      if (change && evt_count != EVT_MAX) begin
        evt_count <= evt_count + 8'd1;
      end
    end
  end

  tone_gen #(.TONE_DIV(TONE_DIV)) u_tone (
    .clk   (clk),
    .Rst_n (Rst_n),
    .en    (sound_nx),
    .clr   (tone_clr),
    .tone  (buzz)
  );

endmodule

// File: tb/tb_smart_home_annunciator.sv
// Directed bench for smart_home_annunciator with hand-computed expectations.
module tb_smart_home_annunciator;

  localparam int DOOR_HOLD = 8;
  localparam int TONE_DIV  = 4;
  localparam int CADENCE   = 16;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S6 = 7'b1111101;

  logic       clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] display_in = 3'b000;
  logic       ack = 1'b0;
  logic       door_open_f, door_open_r, buzz, busy;
  logic [6:0] seg;
  logic [7:0] evt_count;

  int n_checks = 0;
  int n_pass   = 0;
  int evt_exp  = 0;

  smart_home_annunciator #(
    .DOOR_HOLD (DOOR_HOLD),
    .TONE_DIV  (TONE_DIV),
    .CADENCE   (CADENCE)
  ) dut (
    .clk         (clk),
    .Rst_n       (Rst_n),
    .display_in  (display_in),
    .ack         (ack),
    .door_open_f (door_open_f),
    .door_open_r (door_open_r),
    .buzz        (buzz),
    .seg         (seg),
    .evt_count   (evt_count),
    .busy        (busy)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock, then settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic alarm_buzz(input int k);
    return ((((k - 1) / TONE_DIV) % 2) == 0);
  endfunction

  function automatic logic window_buzz(input int k);
    int p;
    p = (k - 1) % (2 * CADENCE);
    if (p >= CADENCE) return 1'b0;
    return (((p / TONE_DIV) % 2) == 0);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_door_f", door_open_f, 0);
    check("rst_door_r", door_open_r, 0);
    check("rst_buzz",   buzz, 0);
    check("rst_busy",   busy, 0);
    check("rst_seg",    seg, S0);
    check("rst_evt",    evt_count, 0);
    #3 Rst_n = 1'b1;
    step();
    check("idle_seg", seg, S0);
    check("idle_evt", evt_count, 0);

    // Front door: 8-cycle pulse starting on the entry edge.
    display_in = 3'b001;
    evt_exp = sat_inc(evt_exp);
    for (int k = 1; k <= 20; k++) begin
      step();
      check("door_f_pulse", door_open_f, (k <= DOOR_HOLD));
      check("door_f_busy",  busy, (k <= DOOR_HOLD));
      if (k == 1) begin
        check("door_f_seg", seg, S1);
        check("door_f_evt", evt_count, evt_exp);
      end
    end

    // Alarm tone, then ack at cycle 10 mutes from cycle 11.
    display_in = 3'b011;
    evt_exp = sat_inc(evt_exp);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("alarm_buzz", buzz, alarm_buzz(k));
      check("alarm_busy", busy, 1);
    end
    check("alarm_seg", seg, S3);
    check("alarm_evt", evt_count, evt_exp);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("mute_buzz", buzz, 0);
    check("mute_busy", busy, 0);
    for (int k = 12; k <= 20; k++) begin
      ack = (k == 15);
      step();
      check("muted_buzz", buzz, 0);
      check("muted_busy", busy, 0);
    end
    ack = 1'b0;
    display_in = 3'b000;
    evt_exp = sat_inc(evt_exp);
    step();
    check("back_idle_seg", seg, S0);
    check("back_idle_evt", evt_count, evt_exp);
    check("back_idle_buzz", buzz, 0);
    display_in = 3'b011;
    evt_exp = sat_inc(evt_exp);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("realarm_buzz", buzz, alarm_buzz(k));
      check("realarm_busy", busy, 1);
    end
    check("realarm_evt", evt_count, evt_exp);

    // Window with ack on the same edge as the change: not muted.
    display_in = 3'b100;
    ack = 1'b1;
    evt_exp = sat_inc(evt_exp);
    for (int k = 1; k <= 64; k++) begin
      step();
      ack = 1'b0;
      check("window_buzz", buzz, window_buzz(k));
      check("window_busy", busy, 1);
    end
    check("window_seg", seg, S4);
    check("window_evt", evt_count, evt_exp);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("window_mute_buzz", buzz, 0);
    check("window_mute_busy", busy, 0);

    // Rear door cut short after 3 cycles.
    display_in = 3'b010;
    evt_exp = sat_inc(evt_exp);
    step();
    check("door_r_seg", seg, S2);
    check("door_r_c1", door_open_r, 1);
    check("door_r_f", door_open_f, 0);
    step();
    check("door_r_c2", door_open_r, 1);
    step();
    check("door_r_c3", door_open_r, 1);
    display_in = 3'b000;
    evt_exp = sat_inc(evt_exp);
    step();
    check("door_r_drop", door_open_r, 0);
    check("door_r_busy", busy, 0);
    check("door_r_evt", evt_count, evt_exp);
    step();
    check("door_r_stay", door_open_r, 0);

    // Cooler codes fold together; ack ignored in COOL.
    display_in = 3'b110;
    evt_exp = sat_inc(evt_exp);
    step();
    check("cool_evt", evt_count, evt_exp);
    display_in = 3'b111;
    step();
    check("cool_alias_evt", evt_count, evt_exp);
    check("cool_alias_seg", seg, S6);
    display_in = 3'b110;
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("cool_back_evt", evt_count, evt_exp);
    check("cool_ack_buzz", buzz, 0);
    check("cool_ack_busy", busy, 0);

    // Saturation over 300 HEAT/COOL changes.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0)      display_in = 3'b101;
      else if (i % 4 == 1) display_in = 3'b110;
      else                 display_in = 3'b111;
      evt_exp = sat_inc(evt_exp);
      step();
      check("sat_evt", evt_count, evt_exp);
      check("sat_seg", seg, (i % 2 == 0) ? S5 : S6);
      check("sat_buzz", buzz, 0);
    end
    check("sat_final", evt_count, 8'hFF);

    // Async reset in the middle of an alarm tone.
    display_in = 3'b011;
    repeat (3) step();
    check("pre_rst_buzz", buzz, 1);
    #3 Rst_n = 1'b0;
    #1;
    check("async_buzz", buzz, 0);
    check("async_busy", busy, 0);
    check("async_evt",  evt_count, 0);
    check("async_seg",  seg, S0);
    #2 Rst_n = 1'b1;
    step();
    check("post_rst_evt",  evt_count, 1);
    check("post_rst_buzz", buzz, 1);
    check("post_rst_seg",  seg, S3);
    check("post_rst_busy", busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
